instr_prefetch_buf: RTL

INSTR_PREFETCH_BUF -- requirements
Module: instr_prefetch_buf

---
 rtl/instr_prefetch_buf.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instr_prefetch_buf.sv
// rtl/instr_prefetch_buf.sv - instruction prefetch byte buffer; optional counters under PREFETCH_STATS_EN
module instr_prefetch_buf #(
  parameter int unsigned DEPTH_BYTES = 32,
  parameter int unsigned FETCH_BYTES = 8,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     mem_req_o,
  output logic [63:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [8*FETCH_BYTES-1:0] mem_data_i,
  input  logic                     mem_err_i,
  input  logic                     redirect_i,
  input  logic [63:0]              redirect_pc_i,
  output logic                     instr_valid_o,
  output logic [79:0]              instr_bytes_o,
  output logic [63:0]              instr_pc_o,
  output logic [3:0]               instr_len_o,
  output logic                     instr_err_o,
  input  logic                     consume_i
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]              stat_flush_cnt_o,
  output logic [31:0]              stat_starve_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = AW + 1;
  localparam logic [63:0]   FMASK   = 64'(FETCH_BYTES - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_BYTES);
  localparam logic [CW-1:0] FETCH_C = CW'(FETCH_BYTES);

  logic [7:0]    buf_q [DEPTH_BYTES];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d, skip_q, skip_d;
  logic [63:0]   pc_q, pc_d, addr_q, addr_d, pend_q, pend_d;
  logic          drop_q, drop_d, err_q, err_d;

  logic [CW-1:0] free_bytes, wr_n, len_c;
  logic          have_instr, ack_ok, do_write, do_pop;

  function automatic logic [3:0] icode_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: icode_len = 4'd2;
      4'h7, 4'h8:             icode_len = 4'd9;
      4'h3, 4'h4, 4'h5:       icode_len = 4'd10;
      default:                icode_len = 4'd1;
    endcase
  endfunction

  // Present up to 10 bytes from head; bytes beyond occupancy read as zero so an empty buffer decodes as length 1
  always_comb begin
    instr_bytes_o = '0;
    for (int i = 0; i < 10; i++) begin
      if (CW'(i) < occ_q) instr_bytes_o[i*8 +: 8] = buf_q[head_q + AW'(i)];
    end
  end

  assign instr_len_o   = icode_len(instr_bytes_o[7:4]);
  assign len_c         = CW'(instr_len_o);
  assign have_instr    = occ_q >= len_c;
  assign instr_valid_o = have_instr | err_q;
  assign instr_err_o   = err_q & ~have_instr;
  assign instr_pc_o    = pc_q;
  assign free_bytes    = DEPTH_C - occ_q;
  // A request stays up while a stale beat is owed to us, even though the buffer was flushed
  assign mem_req_o     = ~rst_i & (drop_q | ((free_bytes >= FETCH_C) & ~err_q));
  assign mem_addr_o    = addr_q;
  assign ack_ok        = mem_ack_i & mem_req_o;
  assign do_write      = ack_ok & ~drop_q & ~mem_err_i;
  assign do_pop        = consume_i & have_instr;
  assign wr_n          = FETCH_C - skip_q;

  // Next-state for pointers, occupancy, pc, fetch address and error/drop flags
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    skip_d = skip_q;
    pc_d   = pc_q;
    addr_d = addr_q;
    pend_d = pend_q;
    drop_d = drop_q;
    err_d  = err_q;
    if (redirect_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      err_d  = 1'b0;
      pc_d   = redirect_pc_i;
      skip_d = CW'(redirect_pc_i & FMASK);
      if (mem_req_o && !mem_ack_i) begin
        drop_d = 1'b1;
        pend_d = redirect_pc_i & ~FMASK;
      end else begin
        drop_d = 1'b0;
        addr_d = redirect_pc_i & ~FMASK;
      end
    end else begin
      if (ack_ok) begin
        if (drop_q) begin
          drop_d = 1'b0;
          addr_d = pend_q;
        end else if (mem_err_i) begin
          err_d = 1'b1;
        end else begin
          tail_d = tail_q + AW'(wr_n);
          addr_d = addr_q + 64'(FETCH_BYTES);
          skip_d = '0;
        end
      end
      if (do_pop) begin
        head_d = head_q + AW'(len_c);
        pc_d   = pc_q + 64'(instr_len_o);
      end
      occ_d = occ_q + (do_write ? wr_n : '0) - (do_pop ? len_c : '0);
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      skip_q <= CW'(RESET_PC & FMASK);
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC & ~FMASK;
      pend_q <= '0;
      drop_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      skip_q <= skip_d;
      pc_q   <= pc_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  // Beat write at tail, dropping bytes below the redirect offset on the first beat
  always_ff @(posedge clk_i) begin
    if (!rst_i && !redirect_i && do_write) begin
      for (int i = 0; i < int'(FETCH_BYTES); i++) begin
        if (CW'(i) >= skip_q) buf_q[tail_q + AW'(i) - AW'(skip_q)] <= mem_data_i[i*8 +: 8];
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  // Saturating redirect and starvation counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_flush_cnt_o  <= '0;
      stat_starve_cnt_o <= '0;
    end else begin
      if (redirect_i && stat_flush_cnt_o != 32'hFFFF_FFFF)
        stat_flush_cnt_o <= stat_flush_cnt_o + 32'd1;
      if (!instr_valid_o && stat_starve_cnt_o != 32'hFFFF_FFFF)
        stat_starve_cnt_o <= stat_starve_cnt_o + 32'd1;
    end
  end
`endif

endmodule
